divider_issue: RTL and testbench

//  Request sequencer that sits directly upstream of the divider and feeds it.
//  It accepts (dividend, divisor, tag) requests over a valid/ready handshake

---
 rtl/divider_issue.sv | 127 ++++++++++++
 tb/tb_divider_issue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/divider_issue.sv
// divider_issue: request sequencer that feeds a multi-cycle divider through a 1-entry buffer,
// handling divide-by-zero and divider timeout locally and returning tagged results in order.
module divider_issue #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_dividend,
  input  logic [6:0]       in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [7:0]       div_dividendin,
  output logic [6:0]       div_divisorin,
  input  logic [7:0]       div_quotient,
  input  logic [6:0]       div_remainder,
  input  logic             div_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_quotient,
  output logic [6:0]       out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_err,
  output logic             busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ZERO, START, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic             pend_full_q, pend_full_d, in_rdy_q, in_rdy_d, push, pop;
  logic [7:0]       pend_dvd_q, pend_dvd_d, op_dvd_q, op_dvd_d, q_q, q_d;
  logic [6:0]       pend_dvs_q, pend_dvs_d, op_dvs_q, op_dvs_d, r_q, r_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d, tag_q, tag_d;
  logic [1:0]       err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_comb begin
    state_d    = state_q;
    op_dvd_d   = op_dvd_q;
    op_dvs_d   = op_dvs_q;
    q_d        = q_q;
    r_d        = r_q;
    tag_d      = tag_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    push       = in_valid & in_rdy_q;
    case (state_q)
      IDLE: if (pend_full_q) begin
        pop   = 1'b1;
        tag_d = pend_tag_q;
        if (pend_dvs_q == 7'd0) begin
          {q_d, r_d, err_d} = {8'hFF, 7'h7F, 2'b01};
          state_d = ZERO;
        end else begin
          op_dvd_d = pend_dvd_q;
          op_dvs_d = pend_dvs_q;
          state_d  = START;
        end
      end
      ZERO: state_d = DONE;
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // first RUN cycle may still see the previous operation's valid
        if (div_valid && cnt_q != '0) begin
          {q_d, r_d, err_d} = {div_quotient, div_remainder, 2'b00};
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          {q_d, r_d, err_d} = {8'hFF, 7'h7F, 2'b10};
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    pend_full_d = push | (pend_full_q & ~pop);
    pend_dvd_d  = push ? in_dividend : pend_dvd_q;
    pend_dvs_d  = push ? in_divisor : pend_dvs_q;
    pend_tag_d  = push ? in_tag : pend_tag_q;
    in_rdy_d    = ~pend_full_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      in_rdy_q    <= 1'b0;
      pend_dvd_q  <= '0;
      pend_dvs_q  <= '0;
      pend_tag_q  <= '0;
      op_dvd_q    <= '0;
      op_dvs_q    <= '0;
      q_q         <= '0;
      r_q         <= '0;
      tag_q       <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      in_rdy_q    <= in_rdy_d;
      pend_dvd_q  <= pend_dvd_d;
      pend_dvs_q  <= pend_dvs_d;
      pend_tag_q  <= pend_tag_d;
      op_dvd_q    <= op_dvd_d;
      op_dvs_q    <= op_dvs_d;
      q_q         <= q_d;
      r_q         <= r_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end
  assign in_ready       = in_rdy_q;
  assign div_start      = state_q == START;
  assign div_dividendin = op_dvd_q;
  assign div_divisorin  = op_dvs_q;
  assign out_valid      = state_q == DONE;
  assign out_quotient   = q_q;
  assign out_remainder  = r_q;
  assign out_tag        = tag_q;
  assign out_err        = err_q;
  assign busy           = (state_q != IDLE) | pend_full_q;
endmodule

// File: tb/tb_divider_issue.sv
// tb_divider_issue: directed scenarios against divider_issue with a behavioural 18-cycle divider.
module tb_divider_issue;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_dividend = 0;
  logic [6:0] in_divisor = 0;
  logic [3:0] in_tag = 0;
  logic in_ready, div_start, div_valid, out_valid, busy;
  logic [7:0] div_dividendin, div_quotient, out_quotient;
  logic [6:0] div_divisorin, div_remainder, out_remainder;
  logic [3:0] out_tag;
  logic [1:0] out_err;
  int total = 0, bad = 0, cyc = 0, starts = 0;
  logic en_model = 1, stale = 0, mv = 0, mbusy = 0;
  logic [7:0] ma = 0, mq = 0;
  logic [6:0] mb = 1, mr = 0;
  int mc = 0;

  divider_issue #(.TAG_W(4), .TIMEOUT(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_start(div_start), .div_dividendin(div_dividendin), .div_divisorin(div_divisorin),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_valid(div_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (div_start) starts++;

  // divider model: valid one cycle, 18 cycles after the start cycle
  always @(posedge clk) begin
    mv <= 0;
    if (div_start) begin
      ma <= div_dividendin; mb <= div_divisorin; mc <= 16; mbusy <= 1;
    end else if (mbusy) begin
      if (mc == 0) begin
        mbusy <= 0; mv <= en_model; mq <= ma / mb; mr <= 7'(ma % mb);
      end else mc <= mc - 1;
    end
  end
  assign div_valid = mv | stale;
  assign div_quotient = mq;
  assign div_remainder = mr;

  task automatic send(input logic [7:0] a, input logic [6:0] b, input logic [3:0] t, output int acc);
    in_dividend = a; in_divisor = b; in_tag = t; in_valid = 1; acc = -100;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic take();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    total++; if ({in_ready, div_start, out_valid, busy} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {in_ready, div_start, out_valid, busy}); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== 21'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {out_quotient, out_remainder, out_tag, out_err}); end
    @(negedge clk); reset = 1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_normal();
    int a, c, s0;
    s0 = starts;
    send(200, 7, 3, a);
    wait_out(c);
    total++; if (c !== a + 21) begin bad++; $display("FAIL normal_latency got=%0d exp=%0d", c - a, 21); end
    total++; if (starts - s0 !== 1) begin bad++; $display("FAIL normal_starts got=%0d exp=1", starts - s0); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd28, 7'd4, 4'd3, 2'b00}) begin bad++; $display("FAIL normal_result got=%0d/%0d/%0d/%b exp=28/4/3/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  task automatic test_div_zero();
    int a, c, s0;
    s0 = starts;
    send(55, 0, 4, a);
    wait_out(c);
    total++; if (c !== a + 3) begin bad++; $display("FAIL dz_latency got=%0d exp=3", c - a); end
    total++; if (starts !== s0) begin bad++; $display("FAIL dz_starts got=%0d exp=0", starts - s0); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'hFF, 7'h7F, 4'd4, 2'b01}) begin bad++; $display("FAIL dz_result got=%h/%h/%0d/%b exp=ff/7f/4/01", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  task automatic test_back_to_back();
    int a, c, errs;
    send(10, 3, 5, a);
    wait_out(c);
    total++; if (c !== a + 21) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=21", c - a); end
    in_dividend = 20; in_divisor = 6; in_tag = 6; in_valid = 1;
    @(negedge clk);
    in_dividend = 30; in_divisor = 4; in_tag = 7;
    errs = 0;
    for (int i = 0; i < 9; i++) begin
      if (in_ready !== 1'b0) errs++;
      if ({out_valid, out_quotient, out_remainder, out_tag, out_err} !== {1'b1, 8'd3, 7'd1, 4'd5, 2'b00}) errs++;
      @(negedge clk);
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL b2b_hold got=%0d_errors exp=0", errs); end
    take();
    send(30, 4, 7, a);
    wait_out(c);
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd3, 7'd2, 4'd6, 2'b00}) begin bad++; $display("FAIL b2b_second got=%0d/%0d/%0d/%b exp=3/2/6/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
    wait_out(c);
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd7, 7'd2, 4'd7, 2'b00}) begin bad++; $display("FAIL b2b_third got=%0d/%0d/%0d/%b exp=7/2/7/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  task automatic test_timeout();
    int a, c;
    en_model = 0;
    send(50, 5, 8, a);
    wait_out(c);
    total++; if (c !== a + 27) begin bad++; $display("FAIL to_latency got=%0d exp=27", c - a); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'hFF, 7'h7F, 4'd8, 2'b10}) begin bad++; $display("FAIL to_result got=%h/%h/%0d/%b exp=ff/7f/8/10", out_quotient, out_remainder, out_tag, out_err); end
    take();
    en_model = 1;
    send(50, 5, 9, a);
    wait_out(c);
    total++; if (c !== a + 21) begin bad++; $display("FAIL to_next_latency got=%0d exp=21", c - a); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd10, 7'd0, 4'd9, 2'b00}) begin bad++; $display("FAIL to_next_result got=%0d/%0d/%0d/%b exp=10/0/9/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  task automatic test_stale_valid();
    int a, c;
    stale = 1;
    send(100, 9, 10, a);
    for (int i = 0; i < 10 && cyc < a + 4; i++) @(negedge clk);
    stale = 0;
    wait_out(c);
    total++; if (c !== a + 21) begin bad++; $display("FAIL stale_latency got=%0d exp=21", c - a); end
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd11, 7'd1, 4'd10, 2'b00}) begin bad++; $display("FAIL stale_result got=%0d/%0d/%0d/%b exp=11/1/10/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  task automatic test_mid_reset();
    int a, c, errs;
    send(200, 7, 1, a);
    for (int i = 0; i < 20 && cyc < a + 11; i++) @(negedge clk);
    reset = 0;
    #1;
    total++; if ({in_ready, div_start, out_valid, busy, div_dividendin, div_divisorin, out_quotient, out_remainder, out_tag, out_err} !== 40'd0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", {in_ready, div_start, out_valid, busy, div_dividendin, div_divisorin, out_quotient, out_remainder, out_tag, out_err}); end
    @(negedge clk); @(negedge clk);
    reset = 1;
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ({in_ready, out_valid, busy, div_start} !== 4'b1000) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL midreset_late_valid got=%0d_errors exp=0", errs); end
    send(255, 1, 2, a);
    wait_out(c);
    total++; if ({out_quotient, out_remainder, out_tag, out_err} !== {8'd255, 7'd0, 4'd2, 2'b00}) begin bad++; $display("FAIL midreset_next got=%0d/%0d/%0d/%b exp=255/0/2/00", out_quotient, out_remainder, out_tag, out_err); end
    take();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_zero();
    test_back_to_back();
    test_timeout();
    test_stale_valid();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
